// File: rtl/x25519_pkg.sv
// Shared definitions for the X25519 ladder sequencer: ALU opcodes, FSM states,
// the coordinate register map and the per-bit ladder microcode.
package x25519_pkg;

  typedef enum logic [2:0] {
    OP_INIT   = 3'd0,
    OP_ADD    = 3'd1,
    OP_SUB    = 3'd2,
    OP_MUL    = 3'd3,
    OP_MULA24 = 3'd4,
    OP_CSWAP  = 3'd5,
    OP_INV    = 3'd6
  } alu_op_e;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_LADDER, S_FSWAP, S_INV, S_FMUL, S_DONE
  } state_e;

  localparam logic [3:0] R_X1 = 4'd0;
  localparam logic [3:0] R_X2 = 4'd1;
  localparam logic [3:0] R_Z2 = 4'd2;
  localparam logic [3:0] R_X3 = 4'd3;
  localparam logic [3:0] R_Z3 = 4'd4;
  localparam logic [3:0] R_T0 = 4'd5;
  localparam logic [3:0] R_T1 = 4'd6;
  localparam logic [3:0] R_T2 = 4'd7;
  localparam logic [3:0] R_T3 = 4'd8;
  localparam logic [3:0] R_T4 = 4'd9;
  localparam logic [3:0] R_T5 = 4'd10;
  localparam logic [3:0] R_T6 = 4'd11;

  localparam int STEP_OPS = 18;

  typedef struct packed {
    alu_op_e    op;
    logic [3:0] dst;
    logic [3:0] src_a;
    logic [3:0] src_b;
  } uop_t;

  // One differential add-and-double step; unused source fields are 0.
  localparam uop_t LADDER_ROM [STEP_OPS] = '{
    '{OP_ADD,    R_T0, R_X2, R_Z2},
    '{OP_MUL,    R_T1, R_T0, R_T0},
    '{OP_SUB,    R_T2, R_X2, R_Z2},
    '{OP_MUL,    R_T3, R_T2, R_T2},
    '{OP_SUB,    R_T4, R_T1, R_T3},
    '{OP_ADD,    R_T5, R_X3, R_Z3},
    '{OP_SUB,    R_T6, R_X3, R_Z3},
    '{OP_MUL,    R_T6, R_T6, R_T0},
    '{OP_MUL,    R_T5, R_T5, R_T2},
    '{OP_ADD,    R_T0, R_T6, R_T5},
    '{OP_MUL,    R_X3, R_T0, R_T0},
    '{OP_SUB,    R_T0, R_T6, R_T5},
    '{OP_MUL,    R_T0, R_T0, R_T0},
    '{OP_MUL,    R_Z3, R_X1, R_T0},
    '{OP_MUL,    R_X2, R_T1, R_T3},
    '{OP_MULA24, R_T0, R_T4, 4'd0},
    '{OP_ADD,    R_T0, R_T1, R_T0},
    '{OP_MUL,    R_Z2, R_T4, R_T0}
  };

endpackage

// File: rtl/x25519_ladder_seq.sv
// Montgomery-ladder sequencer: streams a constant-time field-op sequence to an external ALU.
// Build option X25519_CLAMP_EN clamps the latched scalar (decodeScalar25519).
module x25519_ladder_seq
  import x25519_pkg::*;
#(
  parameter int BIT_LENGTH = 256,
  parameter int REG_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIT_LENGTH-1:0] scalar,
  output logic                  busy,
  output logic                  done,
  output logic                  alu_req,
  output logic [2:0]            alu_op,
  output logic [REG_W-1:0]      alu_dst,
  output logic [REG_W-1:0]      alu_src_a,
  output logic [REG_W-1:0]      alu_src_b,
  output logic                  alu_swap,
  input  logic                  alu_ack
);

  localparam int TW = $clog2(BIT_LENGTH);

  state_e                  state;
  logic [BIT_LENGTH-1:0]   k;
  logic [BIT_LENGTH-1:0]   k_in;
  logic [TW-1:0]           t;
  logic                    swap_prev;
  logic                    swap_done;
  logic [4:0]              step;
  uop_t                    uop;
  alu_op_e                 nxt_op;
  logic [REG_W-1:0]        nxt_dst, nxt_a, nxt_b;
  logic                    nxt_swap;

`ifdef X25519_CLAMP_EN
  always_comb begin
    k_in                 = scalar;
    k_in[2:0]            = 3'b000;
    k_in[BIT_LENGTH-1]   = 1'b0;
    k_in[BIT_LENGTH-2]   = 1'b1;
  end
`else
  assign k_in = scalar;
`endif

  assign uop = LADDER_ROM[step];

  // Next command for the current state; a CSWAP opens every ladder bit.
  always_comb begin
    nxt_op   = OP_CSWAP;
    nxt_dst  = '0;
    nxt_a    = '0;
    nxt_b    = '0;
    nxt_swap = 1'b0;
    case (state)
      S_LADDER: begin
        if (!swap_done) begin
          nxt_swap = k[t] ^ swap_prev;
        end else begin
          nxt_op  = uop.op;
          nxt_dst = REG_W'(uop.dst);
          nxt_a   = REG_W'(uop.src_a);
          nxt_b   = REG_W'(uop.src_b);
        end
      end
      S_FSWAP: nxt_swap = swap_prev;
      S_INV: begin
        nxt_op  = OP_INV;
        nxt_dst = REG_W'(R_T0);
        nxt_a   = REG_W'(R_Z2);
      end
      S_FMUL: begin
        nxt_op  = OP_MUL;
        nxt_dst = REG_W'(R_X2);
        nxt_a   = REG_W'(R_X2);
        nxt_b   = REG_W'(R_T0);
      end
      default: ;
    endcase
  end

  // ALU handshake: alu_req and all command fields hold until alu_ack is sampled
  // high with alu_req; alu_req then drops for exactly one cycle before the next
  // command. alu_ack sampled while alu_req is low has no effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      alu_req   <= 1'b0;
      alu_op    <= 3'd0;
      alu_dst   <= '0;
      alu_src_a <= '0;
      alu_src_b <= '0;
      alu_swap  <= 1'b0;
      k         <= '0;
      t         <= '0;
      swap_prev <= 1'b0;
      swap_done <= 1'b0;
      step      <= '0;
    end else if (alu_req) begin
      if (alu_ack) begin
        alu_req <= 1'b0;
        case (state)
          S_INIT: begin
            state     <= S_LADDER;
            swap_done <= 1'b0;
            step      <= '0;
          end
          S_LADDER: begin
            if (!swap_done) begin
              swap_done <= 1'b1;
              swap_prev <= k[t];
            end else if (step == 5'(STEP_OPS - 1)) begin
              swap_done <= 1'b0;
              step      <= '0;
              if (t == '0) state <= S_FSWAP;
              else         t     <= t - TW'(1);
            end else begin
              step <= step + 5'd1;
            end
          end
          S_FSWAP: state <= S_INV;
          S_INV:   state <= S_FMUL;
          S_FMUL: begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            k         <= k_in;
            t         <= TW'(BIT_LENGTH - 1);
            swap_prev <= 1'b0;
            busy      <= 1'b1;
            state     <= S_INIT;
            alu_req   <= 1'b1;
            alu_op    <= OP_INIT;
            alu_dst   <= '0;
            alu_src_a <= '0;
            alu_src_b <= '0;
            alu_swap  <= 1'b0;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          alu_req   <= 1'b1;
          alu_op    <= nxt_op;
          alu_dst   <= nxt_dst;
          alu_src_a <= nxt_a;
          alu_src_b <= nxt_b;
          alu_swap  <= nxt_swap;
        end
      endcase
    end
  end

endmodule

// File: doc/x25519_ladder_seq.md
# x25519_ladder_seq

Parametrised Montgomery-ladder sequencer for X25519 scalar multiplication. Latches a scalar on a start handshake and walks the RFC 7748 ladder bit by bit. Each step issues a fixed, constant-time sequence of field-operation commands to an external field ALU, which owns the coordinate register file, over a req/ack handshake. Sits between the X25519 top-level control and the GF(2^255-19) arithmetic unit. It replaces reset-triggered operation with an explicit start/busy/done interface and supports variable-latency arithmetic.

## Interface
- BIT_LENGTH, 256, scalar width and ladder iteration count
- REG_W, 4, width of ALU register-file indices

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin operation; sampled only in IDLE
- scalar  in  BIT_LENGTH  integer scalar; byte order already converted upstream; sampled with start
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at completion
- alu_req  out  1  command valid
- alu_op  out  3  0 INIT, 1 ADD, 2 SUB, 3 MUL, 4 MULA24, 5 CSWAP, 6 INV
- alu_dst, alu_src_a, alu_src_b  out  REG_W each  register indices
- alu_swap  out  1  swap bit for CSWAP; 0 for every other op
- alu_ack  in  1  ALU accepted and completed the command

## Operation
- Register map: 0 x1, 1 x2, 2 z2, 3 x3, 4 z3, 5..11 temporaries t0..t6.
- INIT makes the ALU set x2=1, z2=0, x3=x1, z3=1.
- States: IDLE, INIT, LADDER, FSWAP, INV, FMUL, DONE.
- IDLE, start=1: latch scalar (clamped if configured), set bit index t=BIT_LENGTH-1, clear swap_prev, go to INIT.
- LADDER, per bit t:
  - CSWAP with alu_swap = k[t] ^ swap_prev; then swap_prev <= k[t].
  - 18 microcode ops, always in this order: t0=x2+z2; t1=t0*t0; t2=x2-z2; t3=t2*t2; t4=t1-t3; t5=x3+z3; t6=x3-z3; t6=t6*t0; t5=t5*t2; t0=t6+t5; x3=t0*t0; t0=t6-t5; t0=t0*t0; z3=x1*t0; x2=t1*t3; t0=a24*t4 (MULA24); t0=t1+t0; z2=t4*t0.
  - After op 18: if t==0 go to FSWAP, else t--.
- FSWAP: CSWAP with alu_swap=swap_prev.
- INV: t0 = z2^-1.
- FMUL: x2 = x2*t0.
- DONE: done=1 for one cycle, busy=0, back to IDLE. The result is in ALU register x2.
- Op total N = 1 + 19·BIT_LENGTH + 3. For 256: N=4868. CSWAP is issued on every bit regardless of swap value (constant time).
- start while busy: ignored.
- Unused source fields: driven 0.

## Timing
- Reset values: busy=0, done=0, alu_req=0, alu_op/dst/src/swap=0. State is IDLE.
- Reset at any point aborts. alu_req is low the cycle after rst is sampled. The ALU's in-flight op is abandoned.
- Handshake:
  - alu_req and all command fields are held stable until alu_ack is sampled high.
  - alu_req is low for exactly one cycle after each ack.
  - alu_ack while alu_req=0 is ignored.
- start sampled at cycle 0 → first req at cycle 1.
- Zero-wait ALU (ack same cycle as req): 2 cycles per op; done at cycle 2N (9736).
- Ack delayed d cycles after req: (d+2) cycles per op; done at cycle (d+2)·N.
- The bit-index counter never wraps: t==0 on the last step is the terminal condition.

## Configuration
- X25519_CLAMP_EN defined: scalar is latched as k with bits [2:0]=0, bit BIT_LENGTH-1=0, bit BIT_LENGTH-2=1 (RFC 7748 decodeScalar25519).
- X25519_CLAMP_EN undefined: scalar is used verbatim; callers clamp upstream.
- Op count and timing are identical in both builds.

## Structure
- Package x25519_pkg holds:
  - the alu_op enum
  - register-index constants
  - the 18-entry ladder microcode ROM (op, dst, src_a, src_b)
  - STEP_OPS=18
- No sub-module is required. The microcode ROM is a package constant indexed by a 5-bit step counter.

## Test plan
- RFC 7748 vector:
  - Stimulus: behavioural ALU, x1=9, scalar 0x77076d0a…1db92c2a byte-reversed, clamp on.
  - Required: ALU x2 byte-reversed = 0x8520f0098930a754748b7ddcb43ef75a0dbf3a0d26381af4eba4a98eaa9b4e6a.
- Zero-wait op count:
  - Stimulus: scalar=0, clamp on.
  - Required: 4868 reqs; done at cycle 9736.
  - Required: 257 CSWAPs; swap=1 only at t=254 and t=253; final swap=0.
- Wait states:
  - Stimulus: ack delayed 3 cycles.
  - Required: fields never change while req high; no op issued twice; done at cycle 24340.
- Clamp off:
  - Stimulus: scalar all-ones.
  - Required: swap=1 only at t=255; final swap=1; still 4868 ops.
- Abort:
  - Stimulus: start during busy; later, rst on the cycle of the 1000th ack.
  - Required: the start during busy has no effect. After rst: req=0 and busy=0 next cycle. A fresh start then completes in 9736 cycles.
